vrased_rst_ctrl: RTL
====================

# vrased_rst_ctrl

Downstream reset controller for the VRASED hardware monitors. It collects the violation/reset requests of up to N_SRC monitors (atomicity, key-access, DMA, ...), drives a stretched, registered system reset to the MCU core, and records which monitor caused it. It then waits for the core to fetch from the reset handler before re-arming. Monitor request outputs stay high until the PC reaches RESET_HANDLER; this block absorbs that tail and does not re-trigger on it.

## Interface
- N_SRC, 4: number of violation sources.
- HOLD_CYCLES, 16: sys_rst pulse length in cycles; legal range 1..255.
- WAIT_MAX, 1024: cycles allowed to reach RESET_HANDLER after release; legal range 2..65535.
- RESET_HANDLER, 16'hfffe: PC value that marks reset-vector fetch.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high block reset.
- pc  in  16  current core program counter.
- viol  in  N_SRC  per-monitor reset request; level, sampled every cycle.
- cause_clr  in  1  single-cycle request to clear cause; honoured in IDLE only.
- sys_rst  out  1  registered reset to the core.
- cause  out  N_SRC  sticky record of sources that requested reset since the last clear.
- rst_cnt  out  8  saturating count of reset events started from IDLE or from timeout.
- timeout  out  1  sticky; set when WAIT_MAX expired; cleared by cause_clr.

## Operation
- States: HOLD, WAIT, ARM, IDLE. Internal registers: an 8-bit hold counter and a 16-bit wait counter.
- **reset** asserted:
  - state=HOLD, hold counter=HOLD_CYCLES-1.
  - sys_rst=1, cause=0, rst_cnt=0, timeout=0.
  - This gives a power-on reset pulse.
- **HOLD**:
  - sys_rst=1; hold counter decrements each cycle.
  - When the counter is 0: go to WAIT, sys_rst<=0, wait counter<=0.
  - viol bits are ORed into cause. They do not extend the pulse and do not increment rst_cnt.
- **WAIT**:
  - sys_rst=0; viol ORed into cause but does not trigger; wait counter increments.
  - If pc==RESET_HANDLER: go to ARM.
  - Otherwise, if the wait counter reaches WAIT_MAX-1: go to HOLD with sys_rst<=1, hold counter reloaded, timeout<=1, rst_cnt+1 (saturating).
  - If both happen in the same cycle, pc==RESET_HANDLER wins.
- **ARM**:
  - Exactly one cycle; viol ignored entirely; sys_rst=0; then go to IDLE.
  - This covers the one-cycle registered release of the monitors after they see the handler PC.
- **IDLE**:
  - sys_rst=0.
  - If any viol bit is 1: go to HOLD, sys_rst<=1, hold counter<=HOLD_CYCLES-1, cause<=cause|viol, rst_cnt+1 (saturating at 255).
  - Else if cause_clr=1: cause<=0 and timeout<=0.
  - If viol and cause_clr arrive in the same cycle, viol wins and cause_clr is dropped.
- rst_cnt saturates at 8'hff and never wraps.
- All outputs come straight from registers; there is no combinational input-to-output path.

## Timing
- **Trigger latency:** viol high in IDLE at edge t gives sys_rst=1 from edge t+1.
- **Pulse width:** sys_rst stays high for exactly HOLD_CYCLES cycles and is low at edge t+1+HOLD_CYCLES.
- **Power-on pulse:** reset deasserted at edge r gives sys_rst high through edge r+HOLD_CYCLES-1 (counting the reset cycle as cycle 0). It is low after that.
- **HOLD_CYCLES=1:** a single-cycle pulse, HOLD→WAIT after one cycle.
- **Handler latency:** pc==RESET_HANDLER in WAIT at edge h gives ARM at h+1 and IDLE at h+2. A viol sampled at h+2 or later triggers a new reset.
- **Timeout latency:** with no handler fetch, the timeout re-reset begins WAIT_MAX cycles after WAIT entry.
- **Reset mid-operation:** reset in any state restarts the power-on pulse and clears cause, rst_cnt and timeout.
- **Stuck viol:** a viol still high in IDLE (monitor stuck) re-triggers immediately. This is intended; rst_cnt tracks it.

## Test plan
- **Power-on pulse:** HOLD_CYCLES=16, deassert reset → sys_rst high 16 cycles then low; cause=0, rst_cnt=0. Drive pc=16'hfffe → IDLE two cycles later.
- **Single violation:** in IDLE pulse viol=4'b0001 one cycle → sys_rst high next cycle for 16 cycles; cause=4'b0001, rst_cnt=1. viol held high until pc=16'hfffe → no second reset, rst_cnt stays 1.
- **Accumulated causes:** viol=4'b0010 in IDLE, then 4'b1000 during HOLD → cause=4'b1010, rst_cnt=1, pulse not extended.
- **Timeout:** WAIT_MAX=8, after release keep pc=16'h0000 → sys_rst reasserts 8 cycles after release; timeout=1, rst_cnt=2.
- **Clear priority:** cause_clr alone in IDLE → cause=0, timeout=0. cause_clr together with viol=4'b0100 → reset taken and cause includes 4'b0100.
- **Saturation and mid-operation reset:** 300 violation cycles through the full sequence → rst_cnt=8'hff. Then assert reset mid-HOLD → rst_cnt=0 and a fresh 16-cycle pulse.

Source files
------------

// File: rtl/vrased_rst_ctrl.sv
// vrased_rst_ctrl: downstream reset controller for the VRASED monitors.
// Monitor reset requests become a stretched, registered sys_rst pulse.
// The block records which monitors asked for it, then waits for the core
// to fetch from RESET_HANDLER before it re-arms. The monitors keep their
// request lines high until they see the handler PC, plus one registered
// cycle. That tail is absorbed in HOLD/WAIT/ARM and never re-triggers.
module vrased_rst_ctrl #(
  parameter int          N_SRC         = 4,
  parameter int          HOLD_CYCLES   = 16,     // 1..255
  parameter int          WAIT_MAX      = 1024,   // 2..65535
  parameter logic [15:0] RESET_HANDLER = 16'hfffe
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pc,
  input  logic [N_SRC-1:0] viol,
  input  logic             cause_clr,
  output logic             sys_rst,
  output logic [N_SRC-1:0] cause,
  output logic [7:0]       rst_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_ARM  = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  // The hold counter is loaded with HOLD_CYCLES-1 and counts down to zero.
  // That gives exactly HOLD_CYCLES cycles of sys_rst.
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES - 1);
  // The wait counter starts at 0 on WAIT entry. The timeout fires on the
  // cycle it reads WAIT_MAX-1, which is WAIT_MAX cycles after entry.
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t           state, state_d;
  logic [7:0]       hold_cnt, hold_d;
  logic [15:0]      wait_cnt, wait_d;
  logic             sys_rst_d;
  logic [N_SRC-1:0] cause_d;
  logic [7:0]       rst_cnt_d;
  logic             timeout_d;

  logic       any_viol;
  logic       at_handler;
  logic [7:0] rst_cnt_inc;

  assign any_viol    = |viol;
  assign at_handler  = (pc == RESET_HANDLER);
  // The event counter sticks at 8'hff instead of wrapping.
  assign rst_cnt_inc = (rst_cnt == 8'hff) ? rst_cnt : rst_cnt + 8'd1;

  // State and output registers; reset re-launches the power-on pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HOLD;
      hold_cnt <= HOLD_INIT;
      wait_cnt <= 16'd0;
      sys_rst  <= 1'b1;
      cause    <= '0;
      rst_cnt  <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
      wait_cnt <= wait_d;
      sys_rst  <= sys_rst_d;
      cause    <= cause_d;
      rst_cnt  <= rst_cnt_d;
      timeout  <= timeout_d;
    end
  end

  // Next-state and next-output logic. Every register holds unless a state
  // arm below updates it.
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    wait_d    = wait_cnt;
    sys_rst_d = sys_rst;
    cause_d   = cause;
    rst_cnt_d = rst_cnt;
    timeout_d = timeout;

    case (state)
      // Pulse in progress. Late requests only widen the recorded cause.
      // They neither stretch the pulse nor count as a new event.
      S_HOLD: begin
        sys_rst_d = 1'b1;
        cause_d   = cause | viol;
        if (hold_cnt == 8'd0) begin
          state_d   = S_WAIT;
          sys_rst_d = 1'b0;
          wait_d    = 16'd0;
        end else begin
          hold_d = hold_cnt - 8'd1;
        end
      end

      // Released; waiting for the reset-vector fetch. Monitors are still
      // asserting here, so their requests are logged but never trigger.
      // A handler fetch takes priority over an expiring timer.
      S_WAIT: begin
        sys_rst_d = 1'b0;
        cause_d   = cause | viol;
        if (at_handler) begin
          state_d = S_ARM;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d   = S_HOLD;
          sys_rst_d = 1'b1;
          hold_d    = HOLD_INIT;
          timeout_d = 1'b1;
          rst_cnt_d = rst_cnt_inc;
        end else begin
          wait_d = wait_cnt + 16'd1;
        end
      end

      // One blind cycle. It covers the monitors' registered release after
      // they see the handler PC, so viol is ignored completely here.
      S_ARM: begin
        sys_rst_d = 1'b0;
        state_d   = S_IDLE;
      end

      // Armed. Any request starts a new reset. A clear arriving in the
      // same cycle as a request is dropped, so the new cause is not lost.
      S_IDLE: begin
        sys_rst_d = 1'b0;
        if (any_viol) begin
          state_d   = S_HOLD;
          sys_rst_d = 1'b1;
          hold_d    = HOLD_INIT;
          cause_d   = cause | viol;
          rst_cnt_d = rst_cnt_inc;
        end else if (cause_clr) begin
          cause_d   = '0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_HOLD;
        sys_rst_d = 1'b1;
        hold_d    = HOLD_INIT;
      end
    endcase
  end

endmodule
